if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Parametrised fetch-to-decode buffer. Replaces the single-stage IF/ID register with a DEPTH-entry FIFO of {inst, inst_addr, int_flag}.
- Uses a valid/ready handshake on both sides and supports hold and flush.
- Sits between the IFU fetch stage and the ID decoder. Absorbs fetch bursts while decode stalls, and presents NOP when empty.

Parameters:
- INST_W, 32, instruction width in bits
- ADDR_W, 32, instruction address width in bits
- INT_W, 8, interrupt flag width in bits
- DEPTH, 4, number of entries; power of two, >= 2
- HOLD_W, 3, hold_flag_i width
- HOLD_LEVEL, 1, hold_flag_i value at or above which decode-side pops are blocked
- NOP_INST, 32'h00000013, instruction presented when empty and after reset/flush

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid_i  input  1  fetch offers an entry
- in_ready_o  output  1  queue can accept an entry
- inst_i  input  INST_W  fetched instruction
- inst_addr_i  input  ADDR_W  fetched instruction address
- int_flag_i  input  INT_W  peripheral interrupt flags captured with the instruction
- out_valid_o  output  1  head entry valid
- out_ready_i  input  1  decode accepts the head entry
- inst_o  output  INST_W  head instruction, or NOP_INST when empty
- inst_addr_o  output  ADDR_W  head address, or 0 when empty
- int_flag_o  output  INT_W  head interrupt flags, or 0 when empty
- hold_flag_i  input  HOLD_W  pipeline hold level
- flush_i  input  1  discard all entries (jump/trap)
- count_o  output  clog2(DEPTH)+1  current occupancy

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset, sampled on the clk rising edge:
  - read pointer, write pointer and count go to 0
  - out_valid_o=0, in_ready_o=1
  - inst_o=NOP_INST, inst_addr_o=0, int_flag_o=0, count_o=0
  - reset overrides every other input, including during an in-progress burst
- Control signals:
  - push = in_valid_i & in_ready_o
  - in_ready_o = (count != DEPTH); depends only on registered state
  - hold_en = (hold_flag_i >= HOLD_LEVEL)
  - pop = out_valid_o & out_ready_i & ~hold_en
- Storage: push writes {inst_i, inst_addr_i, int_flag_i} at the write pointer. Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Outputs:
  - out_valid_o = (count != 0)
  - when valid, outputs show the entry at the read pointer; when empty, outputs show NOP_INST/0/0
  - outputs depend only on registered state; there is no combinational path from the inputs
- Latency: an entry pushed at edge N is visible on the outputs after edge N (1 cycle) when the queue was empty.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, with both pointers advancing
- Full: in_ready_o=0, so no push is possible even if a pop occurs in the same cycle. The slot frees on the next cycle.
- Empty: pop cannot occur because out_valid_o=0. A push into an empty queue is not bypassed in the same cycle.
- Hold: hold_en blocks pop only. Pushes continue until full. The head entry and the outputs stay stable throughout the hold.
- Flush:
  - on the next edge, pointers and count go to 0
  - flush has priority over a simultaneous push and pop; the pushed entry is dropped
  - in_ready_o stays driven from state and may be 1 during the flush cycle; the upstream push is discarded
- Flush and hold together: the flush wins.
- Ordering is strict FIFO. No entry is duplicated or lost except by flush or reset.
- count_o reports the registered occupancy, range 0..DEPTH.

Test Plan:
- Reset then idle:
  - assert rst for 2 cycles with in_valid_i=1 → count_o=0, out_valid_o=0, inst_o=32'h00000013, inst_addr_o=0, int_flag_o=0
  - after release → in_ready_o=1
- Fill with decode stalled:
  - DEPTH=4, out_ready_i=0, push addresses 0x100, 0x104, 0x108, 0x10C → count_o=4, in_ready_o=0
  - 5th offer (0x110) is not accepted
  - then out_ready_i=1 → outputs 0x100..0x10C in order, 1 per cycle
- Streaming with wrap:
  - push and pop every cycle for 10 entries (addresses 0x200+4k) → count_o stays 1 and out_valid_o stays 1
  - order is preserved across pointer wrap and no bubbles appear
- Hold:
  - with 2 entries present (head 0x300), hold_flag_i=HOLD_LEVEL for 3 cycles, out_ready_i=1 → inst_addr_o stays 0x300 and count_o does not fall
  - concurrent pushes raise count_o to 4; when the hold drops, pops resume
- Flush priority:
  - count_o=3, assert flush_i with a simultaneous push (0x400) and pop → next cycle count_o=0, out_valid_o=0, inst_o=NOP
  - 0x400 never appears at the outputs
- Interrupt flag carriage:
  - push 0x500 with int_flag_i=8'h01, then 0x504 with int_flag_i=8'h00 → int_flag_o=8'h01 while the head is 0x500, and 8'h00 while the head is 0x504

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: DEPTH-entry FIFO of {inst, inst_addr, int_flag}
// between the IFU and the ID decoder, presenting NOP_INST when empty.
module if_id_queue #(
  parameter int                INST_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                INT_W      = 8,
  parameter int                DEPTH      = 4,
  parameter int                HOLD_W     = 3,
  parameter int                HOLD_LEVEL = 1,
  parameter logic [INST_W-1:0] NOP_INST   = 32'h00000013,
  localparam int               PTR_W      = $clog2(DEPTH),
  localparam int               CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  count_o
);

  localparam logic [HOLD_W-1:0] HOLD_LVL = HOLD_W'(HOLD_LEVEL);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [INT_W-1:0]  int_mem  [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic hold_en;
  logic push;
  logic pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready_o/out_valid_o come from registered state only, so the
  // producer/consumer may drive valid/ready combinationally without a loop.
  assign in_ready_o  = (count != FULL_CNT);
  assign out_valid_o = (count != '0);
  assign hold_en     = (hold_flag_i >= HOLD_LVL);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i & ~hold_en;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        inst_mem[wr_ptr] <= inst_i;
        addr_mem[wr_ptr] <= inst_addr_i;
        int_mem[wr_ptr]  <= int_flag_i;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Empty queue shows a NOP with no address/interrupt so decode sees a bubble.
  always_comb begin
    inst_o      = NOP_INST;
    inst_addr_o = '0;
    int_flag_o  = '0;
    if (out_valid_o) begin
      inst_o      = inst_mem[rd_ptr];
      inst_addr_o = addr_mem[rd_ptr];
      int_flag_o  = int_mem[rd_ptr];
    end
  end

  assign count_o = count;

endmodule
